// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: FSM state, clock mode encoding.
package spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_t;

  typedef enum logic [1:0] {SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3} spi_mode_t;

  function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous reset to a chosen level.
module sync_ff #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p <= {STAGES{RST_VAL}};
    else     sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI target with configurable width, CPOL/CPHA and bit order; all pins are
// synchronized into clk and the protocol runs off edges of the synced sck.
module spi_slave_cfg
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] din,
  output logic             done,
  output logic             busy
);

  localparam int             CNT_W       = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(WIDTH - 1);
  localparam spi_mode_t      MODE        = spi_mode(CPOL, CPHA);
  localparam bit             SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d;
  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;

  spi_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rx_sreg, tx_sreg, rx_next, tx_next;
  logic             tx_bit;

  // Stage p0: pin synchronizers
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck),  .q(sck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss),   .q(ss_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  // Stage p1: edge detection against a one-cycle-delayed copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d <= CPOL;
      ss_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  assign lead_edge   = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_d != CPOL) && (sck_s == CPOL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
  assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
  assign ss_fall     = ss_d & ~ss_s;

  assign rx_next = MSB_FIRST ? {rx_sreg[WIDTH-2:0], mosi_s} : {mosi_s, rx_sreg[WIDTH-1:1]};
  assign tx_next = MSB_FIRST ? {tx_sreg[WIDTH-2:0], 1'b0}   : {1'b0, tx_sreg[WIDTH-1:1]};
  assign tx_bit  = MSB_FIRST ? tx_sreg[WIDTH-1] : tx_sreg[0];

  // Stage p2: control FSM, bit counter and word delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SPI_IDLE;
      cnt   <= '0;
      din   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SPI_IDLE: begin
          if (ss_fall) begin
            state <= SPI_ACTIVE;
            cnt   <= '0;
          end
        end
        SPI_ACTIVE: begin
          if (ss_s) begin
            // Deselect always wins, even over a coincident final sample.
            state <= SPI_IDLE;
            cnt   <= '0;
          end else if (sample_edge) begin
            if (cnt == LAST) begin
              din  <= rx_next;
              done <= 1'b1;
              cnt  <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

  // A shift at cnt==0 is the first shift point of a word, so it loads dout:
  // the CPHA=1 first bit, or the back-to-back reload after a wrap with CPHA=0.
  always_ff @(posedge clk) begin
    if (state == SPI_IDLE && ss_fall) begin
      tx_sreg <= dout;
    end else if (state == SPI_ACTIVE && !ss_s) begin
      if (sample_edge) rx_sreg <= rx_next;
      if (shift_edge)  tx_sreg <= (cnt == '0) ? dout : tx_next;
    end
  end

  assign busy = (state == SPI_ACTIVE);
  assign miso = (rst || ss_s || state != SPI_ACTIVE) ? 1'bz : tx_bit;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: three configurations driven by a behavioural SPI master,
// received words checked by a done-triggered scoreboard.
module tb_spi_slave_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mosi = 1'b0;
  logic        sck_v [3];
  logic        ss_v  [3];
  logic        miso_v[3];
  logic        busy_v[3];
  logic        done_v[3];
  logic [31:0] din_v [3];

  logic [7:0]  dout0 = 8'h00, dout1 = 8'h00, din0, din1;
  logic [15:0] dout2 = 16'h0000, din2;
  wire         miso0, miso1, miso2;
  logic        done0, done1, done2, busy0, busy1, busy2;

  // Released miso lines float high so a tri-stated output is observable.
  pullup (miso0);
  pullup (miso1);
  pullup (miso2);

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  spi_slave_cfg #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .sck(sck_v[0]), .ss(ss_v[0]), .mosi(mosi), .miso(miso0),
    .dout(dout0), .din(din0), .done(done0), .busy(busy0)
  );
  spi_slave_cfg #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sck(sck_v[1]), .ss(ss_v[1]), .mosi(mosi), .miso(miso1),
    .dout(dout1), .din(din1), .done(done1), .busy(busy1)
  );
  spi_slave_cfg #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .sck(sck_v[2]), .ss(ss_v[2]), .mosi(mosi), .miso(miso2),
    .dout(dout2), .din(din2), .done(done2), .busy(busy2)
  );

  assign miso_v[0] = miso0;
  assign miso_v[1] = miso1;
  assign miso_v[2] = miso2;
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign busy_v[2] = busy2;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign done_v[2] = done2;
  assign din_v[0]  = {24'h0, din0};
  assign din_v[1]  = {24'h0, din1};
  assign din_v[2]  = {16'h0, din2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural master: half-period 50 ns (sck 10 MHz). Sends nsend bits of tx,
  // captures miso at its own sample point and counts sample points with busy low.
  task automatic xfer(input int id, input logic [31:0] tx, input int n,
                      input bit cpol, input bit cpha, input bit msb,
                      input int nsend, input bit raise_ss,
                      output logic [31:0] rx, output int busy_low);
    int b;
    rx = '0;
    busy_low = 0;
    @(posedge clk);
    #2;
    ss_v[id] = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      b = msb ? (n - 1 - i) : i;
      if (!cpha) begin
        mosi = tx[b];
        #50;
        sck_v[id] = ~cpol;
        rx[b] = miso_v[id];
        if (!busy_v[id]) busy_low++;
        #50;
        sck_v[id] = cpol;
      end else begin
        #50;
        sck_v[id] = ~cpol;
        mosi = tx[b];
        #50;
        sck_v[id] = cpol;
        rx[b] = miso_v[id];
        if (!busy_v[id]) busy_low++;
      end
    end
    #50;
    if (raise_ss) begin
      ss_v[id] = 1'b1;
      #200;
    end
  endtask

  logic [31:0] sb_exp;
  bit          sb_got;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (done_v[k]) begin
          sb_got = 1'b0;
          sb_exp = '0;
          case (k)
            0: if (q0.size() > 0) begin sb_exp = q0.pop_front(); sb_got = 1'b1; end
            1: if (q1.size() > 0) begin sb_exp = q1.pop_front(); sb_got = 1'b1; end
            default: if (q2.size() > 0) begin sb_exp = q2.pop_front(); sb_got = 1'b1; end
          endcase
          checks++;
          if (!sb_got) begin
            errors++;
            $display("FAIL sb_unexpected_done dut%0d: got done with din %h expected no done", k, din_v[k]);
          end else if (din_v[k] !== sb_exp) begin
            errors++;
            $display("FAIL sb_din dut%0d: got %h expected %h", k, din_v[k], sb_exp);
          end
        end
      end
    end
  end

  logic [31:0] rx;
  int          bl;

  initial begin
    sck_v[0] = 1'b0; sck_v[1] = 1'b1; sck_v[2] = 1'b0;
    ss_v[0]  = 1'b1; ss_v[1]  = 1'b1; ss_v[2]  = 1'b1;

    #23;
    chk("rst_din",  din_v[0], 32'h0);
    chk("rst_done", {31'h0, done0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_miso_z", {31'h0, miso0}, 32'h1);
    rst = 1'b0;
    #100;

    // Mode 0 single word
    dout0 = 8'h3C;
    q0.push_back(32'hA5);
    xfer(0, 32'hA5, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1, rx, bl);
    chk("t1_miso_word", rx, 32'h3C);
    chk("t1_busy_low_cnt", bl, 0);
    chk("t1_busy_idle", {31'h0, busy0}, 32'h0);

    // Mode 3, two words in one select window
    dout1 = 8'h55;
    q1.push_back(32'h12);
    q1.push_back(32'h34);
    xfer(1, 32'h12, 8, 1'b1, 1'b1, 1'b1, 8, 1'b0, rx, bl);
    chk("t2_miso_word1", rx, 32'h55);
    dout1 = 8'hAA;
    xfer(1, 32'h34, 8, 1'b1, 1'b1, 1'b1, 8, 1'b1, rx, bl);
    chk("t2_miso_word2", rx, 32'hAA);
    chk("t2_din_final", din_v[1], 32'h34);

    // Mode 0 aborted after 5 bits, then a full word
    dout0 = 8'h00;
    xfer(0, 32'hFF, 8, 1'b0, 1'b0, 1'b1, 5, 1'b0, rx, bl);
    ss_v[0] = 1'b1;
    #35;
    chk("t3_miso_z", {31'h0, miso0}, 32'h1);
    chk("t3_busy_after_abort", {31'h0, busy0}, 32'h0);
    #200;
    chk("t3_din_held", din_v[0], 32'hA5);
    dout0 = 8'h5A;
    q0.push_back(32'hC3);
    xfer(0, 32'hC3, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1, rx, bl);
    chk("t3_miso_word", rx, 32'h5A);

    // Asynchronous reset mid-word
    dout0 = 8'h00;
    xfer(0, 32'hFF, 8, 1'b0, 1'b0, 1'b1, 4, 1'b0, rx, bl);
    #4;
    rst = 1'b1;
    #1;
    chk("t4_din",  din_v[0], 32'h0);
    chk("t4_done", {31'h0, done0}, 32'h0);
    chk("t4_busy", {31'h0, busy0}, 32'h0);
    chk("t4_miso_z", {31'h0, miso0}, 32'h1);
    ss_v[0] = 1'b1;
    #20;
    rst = 1'b0;
    #100;
    dout0 = 8'h7E;
    q0.push_back(32'h81);
    xfer(0, 32'h81, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1, rx, bl);
    chk("t4_miso_word", rx, 32'h7E);

    // Deselect coincident with the final sample edge
    xfer(0, 32'h5A, 8, 1'b0, 1'b0, 1'b1, 7, 1'b0, rx, bl);
    mosi = 1'b0;
    #50;
    sck_v[0] = 1'b1;
    ss_v[0]  = 1'b1;
    #50;
    sck_v[0] = 1'b0;
    #200;
    chk("t6_din_held", din_v[0], 32'h81);

    // 16-bit, LSB first, mode 1
    dout2 = 16'h1234;
    q2.push_back(32'hBEEF);
    xfer(2, 32'hBEEF, 16, 1'b0, 1'b1, 1'b0, 16, 1'b1, rx, bl);
    chk("t5_miso_word", rx, 32'h1234);
    chk("t5_busy_low_cnt", bl, 0);

    #200;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
